fpu_norm_shift_seq: RTL and testbench
=====================================

// Module: fpu_norm_shift_seq
// PURPOSE
//  Multi-cycle mantissa normalizer: the consumer of leading-zero counts. It
//  takes an unnormalized mantissa/exponent pair, left-shifts until the MSB is
//  set and decrements the exponent by the total shift. Each step uses an
//  internal 16-bit lead-0 count of the top chunk. Sits after the FPU add/mul
//  datapath and ahead of rounding; valid/ready on both sides.
// PARAMETERS
//  MANT_W  64  mantissa width; must be a multiple of 16, >=16
//  EXP_W   12  unsigned biased exponent width
//  EMIN    1   smallest normal exponent; shifting never takes exp below it
// PORTS
//  rclk        in   1       clock
//  arst_l      in   1       reset, asynchronous, active-low
//  in_vld      in   1       input operand valid
//  in_rdy      out  1       block can accept an operand
//  in_mant     in   MANT_W  unnormalized mantissa
//  in_exp      in   EXP_W   biased exponent
//  out_vld     out  1       result valid
//  out_rdy     in   1       downstream accepts result
//  out_mant    out  MANT_W  normalized mantissa
//  out_exp     out  EXP_W   adjusted exponent
//  out_zero    out  1       input mantissa was all zero
//  out_denorm  out  1       shift stopped at EMIN with MSB still 0
//  out_shcnt   out  clog2(MANT_W+1) total shift (only with FPU_NORM_SHCNT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; in_rdy=1; out_vld=0;
//    out_mant=0, out_exp=0, out_zero=0, out_denorm=0, out_shcnt=0. Reset
//    mid-operation drops the in-flight operand; nothing is emitted.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. in_rdy=1 only in IDLE. Accept on
//    in_vld&&in_rdy: load mant/exp regs, clear shift accumulator, go SHIFT.
//    A zero mantissa goes straight to DONE: out_zero=1, exp unchanged, out_denorm=0.
//  - SHIFT step (one per cycle), where lz16 = lead-0 count of mant[MSB-:16]
//    and room = exp-EMIN (0 if exp<=EMIN):
//      top chunk zero and room>=16: shift 16, exp-=16, stay SHIFT;
//      else s=min(lz16,room): shift s, exp-=s, go DONE;
//      out_denorm=1 iff resulting MSB is 0 (room-limited).
//    Shifts fill zeros from the LSB. The exponent never underflows or wraps.
//  - Latency: out_vld rises floor(lz/16)+1 edges after the accept edge for
//    nonzero input with sufficient room (lz = total leading zeros); 1 edge
//    for zero input. Exponent-limited ops finish no later.
//  - DONE: out_vld=1, outputs stable until out_rdy. On out_vld&&out_rdy: go
//    IDLE, out_vld=0 next cycle. No accept-in-same-cycle-as-drain: in_rdy
//    rises the cycle after the drain. Throughput is at most one op per
//    (latency+1) cycles.
//  - out_* registers hold their last value while IDLE and SHIFT; valid only with out_vld.
// CONFIGURATION
//  FPU_NORM_SHCNT_EN defined: out_shcnt port present, accumulates the total
//   left shift (0..MANT_W-1), and is cleared on accept.
//  Undefined: port and accumulator are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/SHIFT/DONE) and chunk width
//   constant (16), used by other FPU normalizer variants.
//  One sub-module: fpu_norm_lz16, a combinational 16-bit lead-0 count plus
//   all-zero flag, built from 8-bit counts merged as in the existing lvl3
//   counter. The top level holds the FSM, shifter, exponent subtractor and
//   out regs.
// TESTING
//  1 in_mant=64'h8000_0000_0000_0000, exp=100 -> 1 edge, mant unchanged,
//    exp=100, denorm=0, shcnt=0.
//  2 in_mant=64'h0000_0000_0001_0000, exp=1000 -> 3 edges, mant=64'h8000..0,
//    exp=953, shcnt=47.
//  3 in_mant=0, exp=500 -> 1 edge, out_zero=1, exp=500, mant=0.
//  4 in_mant=64'h0000_0100_0000_0000, exp=EMIN+5 -> exp=1, mant=in<<5,
//    denorm=1.
//  5 out_rdy held 0 for 10 cycles in DONE -> outputs stable, in_rdy=0; random
//    in_vld is not accepted.
//  6 arst_l pulsed low during SHIFT of case 2 -> out_vld stays 0; next
//    operand processed correctly.

Source files
------------

// File: rtl/fpu_norm_shift_seq_pkg.sv
// Shared definitions for the FPU mantissa normalizer variants: FSM encoding
// and the width of the chunk examined by each leading-zero step.
package fpu_norm_shift_seq_pkg;

    localparam int unsigned CHUNK_W = 16;
    localparam int unsigned LZ_W    = $clog2(CHUNK_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } norm_state_e;

endpackage

// File: rtl/fpu_norm_lz16.sv
// Combinational 16-bit leading-zero count plus all-zero flag, built from two
// 8-bit counts merged as in the lvl3 counter.
module fpu_norm_lz16
    import fpu_norm_shift_seq_pkg::*;
(
    input  logic [CHUNK_W-1:0] data_i,
    output logic [LZ_W-1:0]    cnt_o,
    output logic               zero_o
);

    // Returns 8 for an all-zero byte, so bit 3 doubles as the zero flag.
    function automatic logic [3:0] lz8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n = 4'(7 - i);
        end
        return n;
    endfunction

    logic [3:0] lz_hi;
    logic [3:0] lz_lo;

    // Merge byte counts: the low byte only matters when the high byte is empty.
    always_comb begin
        lz_hi  = lz8(data_i[15:8]);
        lz_lo  = lz8(data_i[7:0]);
        zero_o = lz_hi[3] & lz_lo[3];
        if (lz_hi[3]) begin
            cnt_o = 5'(lz_lo) + 5'd8;
        end else begin
            cnt_o = 5'(lz_hi);
        end
    end

endmodule

// File: rtl/fpu_norm_shift_seq.sv
// Multi-cycle mantissa normalizer: shifts left one 16-bit chunk per cycle
// until the MSB is set, never taking the exponent below EMIN.
// Optional feature: define FPU_NORM_SHCNT_EN to add the out_shcnt port.
module fpu_norm_shift_seq
    import fpu_norm_shift_seq_pkg::*;
#(
    parameter int unsigned MANT_W = 64,
    parameter int unsigned EXP_W  = 12,
    parameter int unsigned EMIN   = 1
) (
    input  logic                         rclk,
    input  logic                         arst_l,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [MANT_W-1:0]            in_mant,
    input  logic [EXP_W-1:0]             in_exp,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [MANT_W-1:0]            out_mant,
    output logic [EXP_W-1:0]             out_exp,
    output logic                         out_zero,
    output logic                         out_denorm
`ifdef FPU_NORM_SHCNT_EN
    ,
    output logic [$clog2(MANT_W+1)-1:0]  out_shcnt
`endif
);

    localparam logic [EXP_W-1:0] EminE  = EXP_W'(EMIN);
    localparam logic [EXP_W-1:0] ChunkE = EXP_W'(CHUNK_W);

    norm_state_e state_q, state_d;

    logic [MANT_W-1:0] mant_q;
    logic [EXP_W-1:0]  exp_q;

    logic [LZ_W-1:0]   lz16;
    logic              chunk_zero;
    logic              mant_zero;
    logic [EXP_W-1:0]  room;
    logic              big_step;
    logic [LZ_W-1:0]   step;
    logic [MANT_W-1:0] mant_shift;
    logic [EXP_W-1:0]  exp_step;
    logic              accept;
    logic              finish;

`ifdef FPU_NORM_SHCNT_EN
    localparam int unsigned ShW = $clog2(MANT_W + 1);
    logic [ShW-1:0] shcnt_q;
`endif

    fpu_norm_lz16 u_lz16 (
        .data_i (mant_q[MANT_W-1 -: CHUNK_W]),
        .cnt_o  (lz16),
        .zero_o (chunk_zero)
    );

    // Step size: a whole chunk while room allows, else the smaller of lz16 and room.
    always_comb begin
        mant_zero = (mant_q == '0);
        room      = (exp_q > EminE) ? (exp_q - EminE) : '0;
        big_step  = chunk_zero && (room >= ChunkE);
        if (mant_zero) begin
            step = '0;
        end else if (big_step) begin
            step = LZ_W'(CHUNK_W);
        end else if (EXP_W'(lz16) <= room) begin
            step = lz16;
        end else begin
            step = LZ_W'(room);
        end
        mant_shift = mant_q << step;
        exp_step   = exp_q - EXP_W'(step);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    accept  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (mant_zero || !big_step) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_vld = 1'b1;
                if (out_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Working mantissa/exponent: loaded on accept, shifted each SHIFT cycle.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            mant_q <= '0;
            exp_q  <= '0;
        end else if (accept) begin
            mant_q <= in_mant;
            exp_q  <= in_exp;
        end else if (state_q == StShift) begin
            mant_q <= mant_shift;
            exp_q  <= exp_step;
        end
    end

    // Result registers capture only on the final step and hold otherwise.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            out_mant   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (finish) begin
            out_mant   <= mant_shift;
            out_exp    <= exp_step;
            out_zero   <= mant_zero;
            out_denorm <= !mant_zero && !mant_shift[MANT_W-1];
        end
    end

`ifdef FPU_NORM_SHCNT_EN
    // Total-shift accumulator and its output register.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            shcnt_q   <= '0;
            out_shcnt <= '0;
        end else begin
            if (accept) begin
                shcnt_q <= '0;
            end else if (state_q == StShift) begin
                shcnt_q <= shcnt_q + ShW'(step);
            end
            if (finish) out_shcnt <= shcnt_q + ShW'(step);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_norm_shift_seq.sv
// Directed self-checking bench for fpu_norm_shift_seq (default parameters).
module tb_fpu_norm_shift_seq;

    localparam int unsigned MANT_W = 64;
    localparam int unsigned EXP_W  = 12;

    logic              rclk;
    logic              arst_l;
    logic              in_vld;
    logic              in_rdy;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_vld;
    logic              out_rdy;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_denorm;
`ifdef FPU_NORM_SHCNT_EN
    logic [6:0]        out_shcnt;
`endif

    int total = 0;
    int bad   = 0;

    fpu_norm_shift_seq #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .EMIN   (1)
    ) dut (
        .rclk       (rclk),
        .arst_l     (arst_l),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
`ifdef FPU_NORM_SHCNT_EN
        ,
        .out_shcnt  (out_shcnt)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One operation: issue, measure latency, check results, optionally hold
    // out_rdy low for 'hold' cycles with random in_vld, then drain.
    task automatic run_op(input string tag, input logic [63:0] mant, input logic [11:0] exp,
                          input int lat, input logic [63:0] e_mant, input logic [11:0] e_exp,
                          input logic e_zero, input logic e_den, input int e_sh,
                          input int hold);
        int edges;
        int w;
        w = 0;
        while (!in_rdy && w < 20) begin
            @(posedge rclk); #1;
            w++;
        end
        check({tag, ".rdy"}, 64'(in_rdy), 64'd1);
        in_mant = mant;
        in_exp  = exp;
        in_vld  = 1'b1;
        @(posedge rclk); #1;
        in_vld  = 1'b0;
        in_mant = '0;
        edges   = 0;
        while (!out_vld && edges < 20) begin
            @(posedge rclk); #1;
            edges++;
        end
        check({tag, ".lat"}, 64'(edges), 64'(lat));
        check({tag, ".mant"}, out_mant, e_mant);
        check({tag, ".exp"}, 64'(out_exp), 64'(e_exp));
        check({tag, ".zero"}, 64'(out_zero), 64'(e_zero));
        check({tag, ".den"}, 64'(out_denorm), 64'(e_den));
`ifdef FPU_NORM_SHCNT_EN
        check({tag, ".sh"}, 64'(out_shcnt), 64'(e_sh));
`else
        if (e_sh < 0) $display("note: negative shift in %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            in_vld  = 1'($urandom_range(0, 1));
            in_mant = 64'h0000_0000_0000_0001;
            @(posedge rclk); #1;
            check({tag, ".hvld"}, 64'(out_vld), 64'd1);
            check({tag, ".hrdy"}, 64'(in_rdy), 64'd0);
            check({tag, ".hmant"}, out_mant, e_mant);
            check({tag, ".hexp"}, 64'(out_exp), 64'(e_exp));
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge rclk); #1;
        out_rdy = 1'b0;
        check({tag, ".drain"}, 64'(out_vld), 64'd0);
        check({tag, ".rdy2"}, 64'(in_rdy), 64'd1);
    endtask

    initial begin
        int seen;
        arst_l  = 1'b0;
        in_vld  = 1'b0;
        in_mant = '0;
        in_exp  = '0;
        out_rdy = 1'b0;
        #12;
        check("rst.rdy", 64'(in_rdy), 64'd1);
        check("rst.vld", 64'(out_vld), 64'd0);
        check("rst.mant", out_mant, 64'd0);
        check("rst.exp", 64'(out_exp), 64'd0);
        check("rst.zero", 64'(out_zero), 64'd0);
        check("rst.den", 64'(out_denorm), 64'd0);
`ifdef FPU_NORM_SHCNT_EN
        check("rst.sh", 64'(out_shcnt), 64'd0);
`endif
        arst_l = 1'b1;
        @(posedge rclk); #1;

        run_op("c1", 64'h8000_0000_0000_0000, 12'd100, 1,
               64'h8000_0000_0000_0000, 12'd100, 1'b0, 1'b0, 0, 0);
        run_op("c2", 64'h0000_0000_0001_0000, 12'd1000, 3,
               64'h8000_0000_0000_0000, 12'd953, 1'b0, 1'b0, 47, 0);
        run_op("c3", 64'h0, 12'd500, 1,
               64'h0, 12'd500, 1'b1, 1'b0, 0, 0);
        run_op("c4", 64'h0000_0100_0000_0000, 12'd6, 1,
               64'h0000_2000_0000_0000, 12'd1, 1'b0, 1'b1, 5, 0);
        // Chunk-zero with exactly 16 of room: full step, then a zero-length step.
        run_op("room16", 64'h0000_8000_0000_0000, 12'd17, 2,
               64'h8000_0000_0000_0000, 12'd1, 1'b0, 1'b0, 16, 0);
        // Exponent already below EMIN: no shift at all.
        run_op("below", 64'h0000_0000_0000_0001, 12'd0, 1,
               64'h0000_0000_0000_0001, 12'd0, 1'b0, 1'b1, 0, 0);
        run_op("lz63", 64'h0000_0000_0000_0001, 12'd2000, 4,
               64'h8000_0000_0000_0000, 12'd1937, 1'b0, 1'b0, 63, 0);
        run_op("c5", 64'h0F00_0000_0000_0000, 12'd50, 1,
               64'hF000_0000_0000_0000, 12'd46, 1'b0, 1'b0, 4, 10);

        // Reset in the middle of a multi-step operation.
        in_mant = 64'h0000_0000_0001_0000;
        in_exp  = 12'd1000;
        in_vld  = 1'b1;
        @(posedge rclk); #1;
        in_vld  = 1'b0;
        @(posedge rclk); #1;
        arst_l = 1'b0;
        #2;
        check("c6.rvld", 64'(out_vld), 64'd0);
        check("c6.rrdy", 64'(in_rdy), 64'd1);
        arst_l = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge rclk); #1;
            if (out_vld) seen++;
        end
        check("c6.novld", 64'(seen), 64'd0);
        run_op("c6b", 64'h0000_0000_0001_0000, 12'd1000, 3,
               64'h8000_0000_0000_0000, 12'd953, 1'b0, 1'b0, 47, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
